microwave_countdown_timer: RTL and testbench

BCD time-entry and countdown block for the microwave controller. It accepts keypad digits, holds the cook time as four BCD digits (tens of minutes, minutes, tens of seconds, seconds), and counts down once per second while running. Its digit outputs feed the 7-segment decoder directly. It also produces run/pause status and a one-cycle completion pulse for the control FSM.

---
 rtl/microwave_countdown_timer.sv | 130 +++++++++++++
 tb/tb_microwave_countdown_timer.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/microwave_countdown_timer.sv
// BCD cook-time entry and once-per-second countdown with run/pause status and a completion pulse.
// All outputs registered; state machine, digits and prescaler update in a single clocked block.
module microwave_countdown_timer #(
  parameter int CLKS_PER_SEC = 50_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_valid,
  input  logic [3:0] key_digit,
  input  logic       start,
  input  logic       stop_clear,
  output logic [3:0] TenMin,
  output logic [3:0] Min,
  output logic [3:0] TenSec,
  output logic [3:0] Sec,
  output logic       running,
  output logic       paused,
  output logic       done
);

  localparam int PW = (CLKS_PER_SEC > 2) ? $clog2(CLKS_PER_SEC) : 1;
  localparam logic [PW-1:0] TERMINAL = PW'(CLKS_PER_SEC - 1);

  typedef enum logic [1:0] {SET, RUN, PAUSE} state_t;

  state_t        state;
  logic [PW-1:0] prescaler;
  logic [3:0]    dec_ten_min, dec_min, dec_ten_sec, dec_sec;
  logic          dec_zero;
  logic          time_nonzero;

  assign time_nonzero = |{TenMin, Min, TenSec, Sec};

  // One-second BCD borrow chain; TenSec wraps to 5 only when borrowed from.
  always_comb begin
    dec_ten_min = TenMin;
    dec_min     = Min;
    dec_ten_sec = TenSec;
    dec_sec     = Sec;
    if (Sec != 4'd0) begin
      dec_sec = Sec - 4'd1;
    end else begin
      dec_sec = 4'd9;
      if (TenSec != 4'd0) begin
        dec_ten_sec = TenSec - 4'd1;
      end else begin
        dec_ten_sec = 4'd5;
        if (Min != 4'd0) begin
          dec_min = Min - 4'd1;
        end else begin
          dec_min     = 4'd9;
          dec_ten_min = TenMin - 4'd1;
        end
      end
    end
  end

  assign dec_zero = ~|{dec_ten_min, dec_min, dec_ten_sec, dec_sec};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= SET;
      prescaler <= '0;
      TenMin    <= 4'd0;
      Min       <= 4'd0;
      TenSec    <= 4'd0;
      Sec       <= 4'd0;
      running   <= 1'b0;
      paused    <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        SET: begin
          if (stop_clear) begin
            {TenMin, Min, TenSec, Sec} <= 16'h0000;
          end else if (start && time_nonzero) begin
            state     <= RUN;
            prescaler <= '0;
            running   <= 1'b1;
          end else if (key_valid && key_digit <= 4'd9) begin
            TenMin <= Min;
            Min    <= TenSec;
            TenSec <= Sec;
            Sec    <= key_digit;
          end
        end
        RUN: begin
          // Pause beats a coincident terminal count: prescaler and digits hold.
          if (stop_clear) begin
            state   <= PAUSE;
            running <= 1'b0;
            paused  <= 1'b1;
          end else if (prescaler == TERMINAL) begin
            prescaler <= '0;
            TenMin    <= dec_ten_min;
            Min       <= dec_min;
            TenSec    <= dec_ten_sec;
            Sec       <= dec_sec;
            if (dec_zero) begin
              state   <= SET;
              running <= 1'b0;
              done    <= 1'b1;
            end
          end else begin
            prescaler <= prescaler + PW'(1);
          end
        end
        PAUSE: begin
          if (stop_clear) begin
            state  <= SET;
            paused <= 1'b0;
            {TenMin, Min, TenSec, Sec} <= 16'h0000;
          end else if (start) begin
            state     <= RUN;
            prescaler <= '0;
            running   <= 1'b1;
            paused    <= 1'b0;
          end
        end
        default: begin
          state   <= SET;
          running <= 1'b0;
          paused  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_microwave_countdown_timer.sv
// Directed scenarios plus random stimulus against a minutes/seconds reference model.
module tb_microwave_countdown_timer;

  localparam int C = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       key_valid = 1'b0;
  logic [3:0] key_digit = 4'd0;
  logic       start = 1'b0;
  logic       stop_clear = 1'b0;
  logic [3:0] TenMin, Min, TenSec, Sec;
  logic       running, paused, done;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: time held as two 2-digit decimal fields (mm, ss); mode 0=SET 1=RUN 2=PAUSE.
  int m_mode = 0, m_mm = 0, m_ss = 0, m_cnt = 0;
  bit m_done = 0;

  microwave_countdown_timer #(.CLKS_PER_SEC(C)) dut (
    .clk(clk), .reset(reset), .key_valid(key_valid), .key_digit(key_digit),
    .start(start), .stop_clear(stop_clear), .TenMin(TenMin), .Min(Min),
    .TenSec(TenSec), .Sec(Sec), .running(running), .paused(paused), .done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] dig();
    return {TenMin, Min, TenSec, Sec};
  endfunction

  function automatic logic [15:0] exp_dig();
    return {4'(m_mm / 10), 4'(m_mm % 10), 4'(m_ss / 10), 4'(m_ss % 10)};
  endfunction

  task automatic model_reset();
    m_mode = 0; m_mm = 0; m_ss = 0; m_cnt = 0; m_done = 0;
  endtask

  task automatic model_step(input bit sc, input bit st, input bit kv, input int kd);
    m_done = 0;
    case (m_mode)
      0: if (sc) begin
           m_mm = 0; m_ss = 0;
         end else if (st && (m_mm != 0 || m_ss != 0)) begin
           m_mode = 1; m_cnt = 0;
         end else if (kv && kd <= 9) begin
           m_mm = (m_mm % 10) * 10 + m_ss / 10;
           m_ss = (m_ss % 10) * 10 + kd;
         end
      1: if (sc) begin
           m_mode = 2;
         end else if (m_cnt == C - 1) begin
           m_cnt = 0;
           if (m_ss > 0) m_ss = m_ss - 1;
           else begin m_mm = m_mm - 1; m_ss = 59; end
           if (m_mm == 0 && m_ss == 0) begin m_mode = 0; m_done = 1; end
         end else begin
           m_cnt = m_cnt + 1;
         end
      default: if (sc) begin
           m_mode = 0; m_mm = 0; m_ss = 0;
         end else if (st) begin
           m_mode = 1; m_cnt = 0;
         end
    endcase
  endtask

  task automatic tick(input bit sc, input bit st, input bit kv, input logic [3:0] kd);
    stop_clear = sc; start = st; key_valid = kv; key_digit = kd;
    @(posedge clk);
    model_step(sc, st, kv, int'(kd));
    #1;
    stop_clear = 1'b0; start = 1'b0; key_valid = 1'b0;
  endtask

  task automatic key(input logic [3:0] d);
    tick(1'b0, 1'b0, 1'b1, d);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 1'b0, 4'd0);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (dig() !== 16'h0000 || running !== 1'b0 || paused !== 1'b0 || done !== 1'b0) begin
      n_bad++;
      $display("FAIL reset: got %h r=%b p=%b d=%b, want 0000 r=0 p=0 d=0", dig(), running, paused, done);
    end
    reset = 1'b0;
  endtask

  task automatic test_entry();
    key(4'd1); key(4'd3); key(4'd0);
    n_cmp++;
    if (dig() !== 16'h0130) begin
      n_bad++; $display("FAIL entry: got %h, want 0130", dig());
    end
    key(4'd12);
    n_cmp++;
    if (dig() !== 16'h0130 || running !== 1'b0) begin
      n_bad++; $display("FAIL entry_ignore12: got %h r=%b, want 0130 r=0", dig(), running);
    end
    tick(1'b1, 1'b0, 1'b0, 4'd0);
  endtask

  task automatic test_short_countdown();
    key(4'd2);
    tick(1'b0, 1'b1, 1'b0, 4'd0);
    n_cmp++;
    if (running !== 1'b1) begin
      n_bad++; $display("FAIL short_start: running=%b, want 1", running);
    end
    idle(4);
    n_cmp++;
    if (dig() !== 16'h0001 || running !== 1'b1) begin
      n_bad++; $display("FAIL short_e4: got %h r=%b, want 0001 r=1", dig(), running);
    end
    idle(4);
    n_cmp++;
    if (dig() !== 16'h0000 || done !== 1'b1 || running !== 1'b0) begin
      n_bad++; $display("FAIL short_e8: got %h d=%b r=%b, want 0000 d=1 r=0", dig(), done, running);
    end
    idle(1);
    n_cmp++;
    if (done !== 1'b0) begin
      n_bad++; $display("FAIL short_e9: done=%b, want 0", done);
    end
  endtask

  task automatic test_borrow();
    key(4'd1); key(4'd0); key(4'd0); key(4'd0);
    tick(1'b0, 1'b1, 1'b0, 4'd0);
    idle(4);
    n_cmp++;
    if (dig() !== 16'h0959) begin
      n_bad++; $display("FAIL borrow_1: got %h, want 0959", dig());
    end
    idle(4);
    n_cmp++;
    if (dig() !== 16'h0958) begin
      n_bad++; $display("FAIL borrow_2: got %h, want 0958", dig());
    end
    tick(1'b1, 1'b0, 1'b0, 4'd0);
    tick(1'b1, 1'b0, 1'b0, 4'd0);
  endtask

  task automatic test_pause();
    key(4'd5);
    tick(1'b0, 1'b1, 1'b0, 4'd0);
    idle(1);
    tick(1'b1, 1'b0, 1'b0, 4'd0);
    for (int i = 0; i < 10; i++) begin
      n_cmp++;
      if (dig() !== 16'h0005 || paused !== 1'b1 || running !== 1'b0) begin
        n_bad++; $display("FAIL pause_hold[%0d]: got %h p=%b r=%b, want 0005 p=1 r=0", i, dig(), paused, running);
      end
      idle(1);
    end
    tick(1'b0, 1'b1, 1'b0, 4'd0);
    idle(3);
    n_cmp++;
    if (dig() !== 16'h0005 || running !== 1'b1 || paused !== 1'b0) begin
      n_bad++; $display("FAIL resume_early: got %h r=%b p=%b, want 0005 r=1 p=0", dig(), running, paused);
    end
    idle(1);
    n_cmp++;
    if (dig() !== 16'h0004) begin
      n_bad++; $display("FAIL resume_dec: got %h, want 0004", dig());
    end
    tick(1'b1, 1'b0, 1'b0, 4'd0);
    n_cmp++;
    if (paused !== 1'b1 || dig() !== 16'h0004) begin
      n_bad++; $display("FAIL pause2: got %h p=%b, want 0004 p=1", dig(), paused);
    end
    tick(1'b1, 1'b0, 1'b0, 4'd0);
    n_cmp++;
    if (dig() !== 16'h0000 || paused !== 1'b0 || running !== 1'b0) begin
      n_bad++; $display("FAIL clear: got %h p=%b r=%b, want 0000 p=0 r=0", dig(), paused, running);
    end
  endtask

  task automatic test_priority();
    tick(1'b0, 1'b1, 1'b0, 4'd0);
    n_cmp++;
    if (running !== 1'b0) begin
      n_bad++; $display("FAIL start_at_zero: running=%b, want 0", running);
    end
    key(4'd1); key(4'd0); key(4'd0);
    tick(1'b1, 1'b1, 1'b0, 4'd0);
    n_cmp++;
    if (dig() !== 16'h0000 || running !== 1'b0) begin
      n_bad++; $display("FAIL clear_beats_start: got %h r=%b, want 0000 r=0", dig(), running);
    end
  endtask

  task automatic test_async_reset();
    key(4'd3); key(4'd7);
    tick(1'b0, 1'b1, 1'b0, 4'd0);
    idle(2);
    #2 reset = 1'b1;
    model_reset();
    #1;
    n_cmp++;
    if (dig() !== 16'h0000 || running !== 1'b0 || paused !== 1'b0 || done !== 1'b0) begin
      n_bad++; $display("FAIL async_reset: got %h r=%b p=%b d=%b, want 0000 0 0 0", dig(), running, paused, done);
    end
    @(posedge clk);
    #2 reset = 1'b0;
    key(4'd5);
    tick(1'b0, 1'b1, 1'b0, 4'd0);
    for (int i = 0; i < 5 * C; i++) begin
      idle(1);
      n_cmp++;
      if (dig() !== exp_dig() || running !== (m_mode == 1) || done !== m_done) begin
        n_bad++; $display("FAIL post_reset[%0d]: got %h r=%b d=%b, want %h r=%b d=%b", i, dig(), running, done, exp_dig(), m_mode == 1, m_done);
      end
    end
    n_cmp++;
    if (dig() !== 16'h0000 || done !== 1'b1) begin
      n_bad++; $display("FAIL post_reset_end: got %h d=%b, want 0000 d=1", dig(), done);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      tick($urandom_range(0, 24) == 0, $urandom_range(0, 9) == 0,
           $urandom_range(0, 3) == 0, 4'($urandom_range(0, 15)));
      n_cmp++;
      if (dig() !== exp_dig() || running !== (m_mode == 1) || paused !== (m_mode == 2) ||
          done !== m_done || (running && paused)) begin
        n_bad++;
        $display("FAIL random[%0d]: got %h r=%b p=%b d=%b, want %h r=%b p=%b d=%b", i, dig(),
                 running, paused, done, exp_dig(), m_mode == 1, m_mode == 2, m_done);
      end
    end
  endtask

  initial begin
    test_reset();
    test_entry();
    test_short_countdown();
    test_borrow();
    test_pause();
    test_priority();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
